// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer and the sound sheet ROM.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package song_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

    // Periods at or below this value produce no tone.
    localparam int NOTE_SILENCE = 1;

    // 1/16 s per duration tick at 50 MHz.
    localparam int DEFAULT_TICK_CYCLES = 3125000;

    // Field widths shared with the sound sheet ROM.
    localparam int NOTE_W = 20;
    localparam int DUR_W  = 5;

endpackage

// File: rtl/song_player_tone_gen.sv
// Square-wave generator: high for floor(period/2) cycles, low for the rest.
// Latency: speaker is registered; first high level one cycle after en rises.
// Backpressure: none; en=0 clears the phase counter and silences the output.
module tone_gen #(
    parameter int NOTE_W = song_pkg::NOTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NOTE_W-1:0] period,
    output logic              speaker
);
    import song_pkg::*;

    logic [NOTE_W-1:0] period_cnt;
    logic              audible;
    logic              period_wrap;

    // Silent periods and the end of a full period both restart the phase.
    always_comb begin
        audible     = (period > NOTE_W'(NOTE_SILENCE));
        period_wrap = !audible || (period_cnt >= period - NOTE_W'(1));
    end

    // Phase counter and registered high/low compare.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            period_cnt <= '0;
            speaker    <= 1'b0;
        end else begin
            speaker    <= audible && (period_cnt < (period >> 1));
            period_cnt <= period_wrap ? '0 : period_cnt + NOTE_W'(1);
        end
    end

endmodule

// File: rtl/song_player.sv
// Walks the sound sheet from index 0 to LAST_INDEX, holding each note duration*TICK_CYCLES cycles.
// Latency: one LOAD cycle per note, then PLAY; speaker registered, done pulses one cycle at song end.
// Backpressure: none; stop aborts at once and wins over start, start ignored while busy.
// Build option: SONG_PLAYER_LOOP_EN restarts from index 0 after the last note instead of stopping.
module song_player #(
    parameter int TICK_CYCLES = song_pkg::DEFAULT_TICK_CYCLES,
    parameter int LAST_INDEX  = 32,
    parameter int NOTE_W      = song_pkg::NOTE_W,
    parameter int DUR_W       = song_pkg::DUR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    output logic [9:0]        number,
    output logic              speaker,
    output logic              busy,
    output logic              done
);
    import song_pkg::*;

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  dur_q;
    logic [TICK_W-1:0] tick_cnt;
    logic [DUR_W-1:0]  dur_cnt;
    logic              tick_wrap;
    logic              note_end;
    logic              advance;
    logic              at_last;
    logic              tone_en;

    // Note-boundary decode: a note ends on the final tick wrap, or in LOAD when its duration is 0.
    always_comb begin
        tick_wrap = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
        note_end  = (state == PLAY) && tick_wrap && (dur_cnt == dur_q - DUR_W'(1));
        advance   = note_end || ((state == LOAD) && (duration == '0));
        at_last   = (number == 10'(LAST_INDEX));
        tone_en   = (state == PLAY) && !stop && !note_end;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_nxt = state;
        busy      = (state == LOAD) || (state == PLAY);
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = PLAY;
            PLAY:    state_nxt = PLAY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (advance) begin
`ifdef SONG_PLAYER_LOOP_EN
            state_nxt = LOAD;
`else
            state_nxt = at_last ? DONE : LOAD;
`endif
        end
        if (stop) begin
            state_nxt = IDLE;
        end
    end

    // Sheet index, note latches, tick/duration counters and the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            number   <= '0;
            note_q   <= '0;
            dur_q    <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            done     <= 1'b0;
        end else if (stop) begin
            number   <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= advance && at_last;
            if (state == LOAD) begin
                note_q   <= note;
                dur_q    <= duration;
                tick_cnt <= '0;
                dur_cnt  <= '0;
            end else if (state == PLAY) begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                if (tick_wrap) begin
                    dur_cnt <= dur_cnt + DUR_W'(1);
                end
            end
            if (advance) begin
                if (!at_last) begin
                    number <= number + 10'd1;
                end else begin
`ifdef SONG_PLAYER_LOOP_EN
                    number <= '0;
`else
                    number <= number;
`endif
                end
            end else if ((state == IDLE) || (state == DONE)) begin
                number <= '0;
            end
        end
    end

    tone_gen #(
        .NOTE_W (NOTE_W)
    ) u_tone_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (tone_en),
        .period  (note_q),
        .speaker (speaker)
    );

endmodule

// File: tb/tb_song_player.sv
module tb_song_player;

    localparam int TICK = 4;
    localparam int LAST = 3;
    localparam int NW   = 20;
    localparam int DW   = 5;

    typedef struct packed {
        logic [9:0] number;
        logic       speaker;
        logic       busy;
        logic       done;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [NW-1:0] note;
    logic [DW-1:0] duration;
    logic [9:0]    number;
    logic          speaker;
    logic          busy;
    logic          done;

    logic [NW-1:0] sheet_note [0:LAST];
    logic [DW-1:0] sheet_dur  [0:LAST];

    obs_t sbq[$];
    obs_t tr[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Combinational stub of the sound sheet ROM.
    assign note     = (number <= 10'(LAST)) ? sheet_note[number[1:0]] : '0;
    assign duration = (number <= 10'(LAST)) ? sheet_dur[number[1:0]]  : '0;

    song_player #(
        .TICK_CYCLES (TICK),
        .LAST_INDEX  (LAST),
        .NOTE_W      (NW),
        .DUR_W       (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .note     (note),
        .duration (duration),
        .number   (number),
        .speaker  (speaker),
        .busy     (busy),
        .done     (done)
    );

    function automatic obs_t mk(input int n, input bit s, input bit b, input bit d);
        obs_t o;
        o.number  = 10'(n);
        o.speaker = s;
        o.busy    = b;
        o.done    = d;
        return o;
    endfunction

    // Reference: expected outputs after each edge, starting with the edge that samples start.
    function automatic void build_trace();
        tr.delete();
        for (int n = 0; n <= LAST; n++) begin
            int p;
            int len;
            p   = int'(sheet_note[n]);
            len = int'(sheet_dur[n]) * TICK;
            tr.push_back(mk(n, 1'b0, 1'b1, 1'b0));
            for (int k = 0; k < len; k++) begin
                bit s;
                s = (k > 0) && (p >= 2) && (((k - 1) % p) < (p / 2));
                tr.push_back(mk(n, s, 1'b1, 1'b0));
            end
        end
`ifdef SONG_PLAYER_LOOP_EN
        tr.push_back(mk(0, 1'b0, 1'b1, 1'b1));
`else
        tr.push_back(mk(LAST, 1'b0, 1'b0, 1'b1));
        tr.push_back(mk(0, 1'b0, 1'b0, 1'b0));
`endif
    endfunction

    // mode 0: run to completion, 1: stop sampled at edge 'at', 2: reset for 3 edges from 'at'.
    task automatic run_song(input int mode_in, input int at_in, input bit noise);
        int   mode;
        int   at;
        obs_t lst[$];
        mode = mode_in;
        at   = at_in;
        build_trace();
`ifdef SONG_PLAYER_LOOP_EN
        if (mode == 0) begin
            mode = 1;
            at   = tr.size();
        end
`endif
        lst = tr;
        if (mode != 0 && at >= 1 && at <= lst.size()) begin
            while (lst.size() > at) void'(lst.pop_back());
            lst.push_back(mk(0, 1'b0, 1'b0, 1'b0));
            if (mode == 2) begin
                for (int r = 0; r < 3; r++) lst.push_back(mk(0, 1'b0, 1'b0, 1'b0));
            end
        end else begin
            mode = 0;
        end
        @(negedge clk);
        foreach (lst[i]) sbq.push_back(lst[i]);
        start = 1'b1;
        for (int c = 1; c < lst.size(); c++) begin
            @(negedge clk);
            start = (noise && lst[c-1].busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop  = (mode == 1 && c == at);
            rst_n = !(mode == 2 && c >= at && c < at + 3);
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b1;
        for (int w = 0; w < 50 && sbq.size() > 0; w++) @(negedge clk);
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected outputs never observed (required 0)", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: one expected observation per clock edge while the scoreboard is non-empty.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            obs_t e;
            obs_t a;
            e = sbq.pop_front();
            a.number  = number;
            a.speaker = speaker;
            a.busy    = busy;
            a.done    = done;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs @%0t: got number=%0d speaker=%b busy=%b done=%b, required number=%0d speaker=%b busy=%b done=%b",
                         $time, a.number, a.speaker, a.busy, a.done, e.number, e.speaker, e.busy, e.done);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i <= LAST; i++) begin
            sheet_note[i] = NW'(8);
            sheet_dur[i]  = DW'(1);
        end

        // Reset state.
        @(negedge clk);
        for (int i = 0; i < 3; i++) sbq.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Tone 8, silence, odd period 5, odd period 7; start noise during play.
        sheet_note[0] = 20'd8; sheet_dur[0] = 5'd2;
        sheet_note[1] = 20'd1; sheet_dur[1] = 5'd2;
        sheet_note[2] = 20'd5; sheet_dur[2] = 5'd3;
        sheet_note[3] = 20'd7; sheet_dur[3] = 5'd2;
        run_song(0, 0, 1'b1);

        // Song end timing: four notes of one tick each.
        for (int i = 0; i <= LAST; i++) begin
            sheet_note[i] = NW'(6);
            sheet_dur[i]  = DW'(1);
        end
        run_song(0, 0, 1'b0);

        // Zero duration at index 1.
        sheet_dur[1] = 5'd0;
        run_song(0, 0, 1'b1);

        // Stop in the third PLAY cycle of the first note.
        sheet_note[0] = 20'd8; sheet_dur[0] = 5'd2;
        run_song(1, 4, 1'b0);

        // Reset held for three cycles during PLAY.
        run_song(2, 6, 1'b0);

        // Start and stop together in IDLE: stop wins.
        @(negedge clk);
        sbq.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized songs with random stop/reset injection.
        for (int it = 0; it < 12; it++) begin
            int mode;
            int at;
            for (int i = 0; i <= LAST; i++) begin
                sheet_note[i] = NW'($urandom_range(0, 12));
                sheet_dur[i]  = DW'($urandom_range(0, 3));
            end
            build_trace();
            mode = $urandom_range(0, 2);
            at   = $urandom_range(1, tr.size() - 1);
            run_song(mode, at, 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Sequencer and tone generator directly downstream of the sound sheet ROM.
- Drives the sheet's 10-bit note index and latches the returned note period and duration.
- Holds each note for duration × tick time and produces a square-wave speaker output at the note's pitch.
- Sits between game-event logic (start/stop) and the board's speaker/PWM pin.

Parameters:
- TICK_CYCLES, 3125000, clk cycles per duration tick (1/16 s at 50 MHz; duration 16 = 1 s).
- LAST_INDEX, 32, final sheet index in the song; must fit in 10 bits.
- NOTE_W, 20, width of the note period field.
- DUR_W, 5, width of the duration field.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset; sampled only on the rising edge of clk.
- start  in  1  level/pulse; begins the song from index 0 when IDLE.
- stop  in  1  aborts playback; takes priority over start.
- note  in  NOTE_W  full period in clk cycles (50e6 / f) from the sheet; value < 2 means silence.
- duration  in  DUR_W  note length in ticks from the sheet.
- number  out  10  sheet index currently requested.
- speaker  out  1  registered square-wave audio output.
- busy  out  1  high in LOAD and PLAY.
- done  out  1  one-cycle pulse when the song completes naturally.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, number=0, speaker=0, busy=0, done=0, and all counters and latches cleared. Reset mid-song silences the speaker on the same edge.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE: number held at 0. If start=1 and stop=0, go to LOAD.
- LOAD (exactly 1 cycle):
  - Latch note → note_q and duration → dur_q; the sheet is combinational, so number is already stable.
  - Clear tick_cnt, dur_cnt and period_cnt.
  - If dur_q would be 0, the note is skipped: take the advance path directly.
  - Otherwise go to PLAY.
- PLAY:
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps.
  - On each wrap, dur_cnt increments.
  - When the wrap occurs with dur_cnt == dur_q-1, the note ends (advance path).
  - Each note therefore occupies 1 + dur_q*TICK_CYCLES cycles.
- Advance path:
  - If number == LAST_INDEX, go to DONE.
  - Otherwise number <= number+1 and go to LOAD.
  - number never exceeds LAST_INDEX.
- DONE (1 cycle): done=1, number <= 0, then IDLE.
- stop=1 in any state: next state IDLE, number=0, speaker=0. done is not asserted.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- Tone (PLAY only):
  - period_cnt counts 0..note_q-1 and wraps.
  - speaker <= (period_cnt < note_q>>1) when note_q ≥ 2, else 0.
  - Speaker is 0 in IDLE, LOAD and DONE.
  - First high edge appears on the cycle after entering PLAY.
- Odd note_q: high for floor(note_q/2) cycles, low for the remainder.
- Counter widths: tick_cnt is ceil(log2(TICK_CYCLES)) bits; dur_cnt is DUR_W bits; period_cnt is NOTE_W bits. No overflow is possible.

Optional Feature:
- Macro: SONG_PLAYER_LOOP_EN.
- Defined: on the advance path at LAST_INDEX, number <= 0 and go to LOAD. done still pulses for 1 cycle alongside that transition. Play continues until stop or reset.
- Undefined: single-shot behaviour through DONE as specified above.

Decomposition:
- Package song_pkg:
  - state enum {IDLE, LOAD, PLAY, DONE}
  - NOTE_SILENCE = 1
  - default TICK_CYCLES
  - NOTE_W and DUR_W constants, shared with the sound sheet
- Sub-module tone_gen:
  - inputs clk, rst_n, en, period[NOTE_W-1:0]
  - output speaker
  - contains period_cnt and the high/low compare
  - en=0 clears the counter and forces speaker 0

Test Plan (TICK_CYCLES=4, LAST_INDEX=3, stub sheet unless noted):
- Reset: hold rst_n=0 for 3 cycles during PLAY → next edge gives speaker=0, number=0, busy=0; no done pulse.
- Tone: note=8, duration=2, start pulse → LOAD for 1 cycle, then PLAY for 8 cycles with speaker pattern 1111 0000; number goes 0→1 on the 9th cycle after LOAD.
- Silence and odd period:
  - note=1 → speaker stays 0 for the whole note.
  - note=5 → speaker repeats 11000.
- Song end: 4 notes each with duration=1 → done pulses exactly once, 4*(1+4) cycles after start was sampled, then IDLE with number=0.
- Stop/start priority:
  - stop asserted in the 3rd PLAY cycle → IDLE and speaker=0 on the next edge.
  - start and stop together in IDLE → stays IDLE.
  - start during PLAY → no effect.
- Zero duration and loop:
  - duration=0 at index 1 → index 1 lasts only its LOAD cycle, then number=2.
  - With SONG_PLAYER_LOOP_EN defined → number wraps 3→0, done pulses, busy stays 1.
